// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage constants, fetch FSM encoding and the
// j/jal target helper used by the IF stage.
package cpu_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] CPU_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_e;

  // j/jal target: upper nibble of the sequential PC, index field, word aligned.
  function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                              input logic [25:0] im26);
    return ((pc + 32'd4) & 32'hF000_0000) | {4'b0000, im26, 2'b00};
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC select for the fetch stage: sequential PC+4 and the
// redirect target, with a taken branch winning over a simultaneous jump.
module if_next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_en,
  input  logic [25:0] jmp_im26,
  input  logic [31:0] jmp_pc_id,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  always_comb begin
    pc_plus4    = pc + 32'd4;
    redirect    = br_taken | jmp_en;
    redirect_pc = br_taken ? br_target : jump_target(jmp_pc_id, jmp_im26);
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, single-outstanding imem request,
// redirect/stall handling. Define IF_FETCH_PERF_EN to add performance counters.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC,
  parameter logic [31:0] NOP_WORD = CPU_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_en,
  input  logic [25:0] jmp_im26,
  input  logic [31:0] jmp_pc_id,
  output logic [31:0] pc_if,
  output logic [31:0] ir_if,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt,
`endif
  output logic        valid_if
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic [31:0]  hold_ir_q, hold_ir_d;
  logic [31:0]  pc_if_q, pc_if_d;
  logic [31:0]  ir_if_q, ir_if_d;
  logic         valid_if_q, valid_if_d;

  logic         redirect;
  logic [31:0]  redirect_pc, pc_plus4;
  logic         deliver, bubble;
  logic [31:0]  deliver_pc, deliver_ir;

  if_next_pc u_next_pc (
    .pc          (pc_q),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_en      (jmp_en),
    .jmp_im26    (jmp_im26),
    .jmp_pc_id   (jmp_pc_id),
    .pc_plus4    (pc_plus4),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    hold_pc_d  = hold_pc_q;
    hold_ir_d  = hold_ir_q;
    pc_if_d    = pc_if_q;
    ir_if_d    = ir_if_q;
    valid_if_d = valid_if_q;
    deliver    = 1'b0;
    bubble     = 1'b0;
    deliver_pc = pc_q;
    deliver_ir = imem_rdata;

    unique case (state_q)
      IDLE: state_d = FETCH;  // a late response from before reset is ignored here

      FETCH: begin
        if (redirect) begin
          pc_d   = redirect_pc;
          bubble = 1'b1;
          if (!imem_ready) begin
            req_addr_d = pc_q;
            state_d    = DISCARD;
          end
        end else if (imem_ready && !stall) begin
          deliver = 1'b1;
          pc_d    = pc_plus4;
        end else if (imem_ready) begin
          hold_pc_d = pc_q;
          hold_ir_d = imem_rdata;
          state_d   = HOLD;
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          bubble  = 1'b1;
          state_d = FETCH;
        end else if (!stall) begin
          deliver    = 1'b1;
          deliver_pc = hold_pc_q;
          deliver_ir = hold_ir_q;
          pc_d       = pc_plus4;
          state_d    = FETCH;
        end
      end

      DISCARD: begin
        // The abandoned request must still complete; only pc tracks new redirects.
        if (redirect) pc_d = redirect_pc;
        bubble = redirect | ~stall;
        if (imem_ready) state_d = FETCH;
      end

      default: state_d = IDLE;
    endcase

    if (deliver) begin
      pc_if_d    = deliver_pc;
      ir_if_d    = deliver_ir;
      valid_if_d = 1'b1;
    end else if (bubble) begin
      ir_if_d    = NOP_WORD;
      valid_if_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_pc_q  <= '0;
      hold_ir_q  <= '0;
      pc_if_q    <= '0;
      ir_if_q    <= NOP_WORD;
      valid_if_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      hold_pc_q  <= hold_pc_d;
      hold_ir_q  <= hold_ir_d;
      pc_if_q    <= pc_if_d;
      ir_if_q    <= ir_if_d;
      valid_if_q <= valid_if_d;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_fetch_d  = perf_fetch_q + {31'd0, deliver};
    perf_bubble_d = perf_bubble_q + {31'd0, bubble & ~stall};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

  assign imem_req  = (state_q == FETCH) || (state_q == DISCARD);
  assign imem_addr = (state_q == DISCARD) ? req_addr_q : pc_q;
  assign pc_if     = pc_if_q;
  assign ir_if     = ir_if_q;
  assign valid_if  = valid_if_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios then random
// stall/redirect/wait-state traffic, all compared against a transaction model.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jmp_en = 1'b0;
  logic [25:0] jmp_im26 = '0;
  logic [31:0] jmp_pc_id = '0;
  logic [31:0] pc_if;
  logic [31:0] ir_if;
  logic        valid_if;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_en     (jmp_en),
    .jmp_im26   (jmp_im26),
    .jmp_pc_id  (jmp_pc_id),
    .pc_if      (pc_if),
    .ir_if      (ir_if),
`ifdef IF_FETCH_PERF_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt),
`endif
    .valid_if   (valid_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: architectural PC, a parked word, a dead request.
  logic        m_started, m_held, m_dead, m_valid;
  logic [31:0] m_pc, m_held_pc, m_held_ir, m_dead_addr, m_pc_if, m_ir_if;
  logic [31:0] m_fetch_cnt, m_bubble_cnt;
  int          mem_cnt, mem_waits;
  logic        rand_mem;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_req();
    return m_started && !m_held;
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_dead ? m_dead_addr : m_pc;
  endfunction

  task automatic model_reset();
    m_started    = 1'b0;
    m_held       = 1'b0;
    m_dead       = 1'b0;
    m_valid      = 1'b0;
    m_pc         = RST_PC;
    m_held_pc    = '0;
    m_held_ir    = '0;
    m_dead_addr  = '0;
    m_pc_if      = '0;
    m_ir_if      = NOP;
    m_fetch_cnt  = '0;
    m_bubble_cnt = '0;
    mem_cnt      = 0;
  endtask

  // Called at a negedge: check outputs, drive one cycle of inputs, advance the model.
  task automatic cycle(input logic s, input logic br, input logic [31:0] bt,
                       input logic j, input logic [25:0] im, input logic [31:0] jpc);
    logic        rdy, req_now, redir, bub, give;
    logic [31:0] tgt, seq, gpc, gir;
    check("pc_if", pc_if, m_pc_if);
    check("ir_if", ir_if, m_ir_if);
    check("valid_if", 32'(valid_if), 32'(m_valid));
    check("imem_req", 32'(imem_req), 32'(exp_req()));
    check("imem_addr", imem_addr, exp_addr());
`ifdef IF_FETCH_PERF_EN
    check("perf_fetch", perf_fetch_cnt, m_fetch_cnt);
    check("perf_bubble", perf_bubble_cnt, m_bubble_cnt);
`endif
    req_now    = exp_req();
    rdy        = req_now && (mem_cnt >= mem_waits);
    imem_ready = rdy || !m_started;
    imem_rdata = rdy ? exp_addr() : 32'hDEAD_BEEF;
    stall      = s;
    br_taken   = br;
    br_target  = bt;
    jmp_en     = j;
    jmp_im26   = im;
    jmp_pc_id  = jpc;

    redir = br | j;
    seq   = jpc + 32'd4;
    tgt   = br ? bt : ((seq & 32'hF000_0000) + 32'(im) * 32'd4);
    bub   = 1'b0;
    give  = 1'b0;
    gpc   = '0;
    gir   = '0;

    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_held) begin
      if (redir) begin
        m_held = 1'b0; m_pc = tgt; bub = 1'b1;
      end else if (!s) begin
        m_held = 1'b0; give = 1'b1; gpc = m_held_pc; gir = m_held_ir; m_pc = m_pc + 32'd4;
      end
    end else if (m_dead) begin
      if (redir) m_pc = tgt;
      bub = redir || !s;
      if (rdy) m_dead = 1'b0;
    end else if (redir) begin
      if (!rdy) begin m_dead = 1'b1; m_dead_addr = m_pc; end
      m_pc = tgt; bub = 1'b1;
    end else if (rdy && !s) begin
      give = 1'b1; gpc = m_pc; gir = imem_rdata; m_pc = m_pc + 32'd4;
    end else if (rdy) begin
      m_held = 1'b1; m_held_pc = m_pc; m_held_ir = imem_rdata;
    end else if (!s) begin
      bub = 1'b1;
    end

    if (give) begin
      m_pc_if = gpc; m_ir_if = gir; m_valid = 1'b1; m_fetch_cnt++;
    end else if (bub) begin
      m_ir_if = NOP; m_valid = 1'b0;
      if (!s) m_bubble_cnt++;
    end

    if (rdy) begin
      mem_cnt = 0;
      if (rand_mem) mem_waits = int'($urandom_range(0, 2));
    end else if (req_now) begin
      mem_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic step();
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
  endtask

  // Called at a negedge; asserts rst_n mid-cycle and checks the asynchronous clear.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_pc_if", pc_if, 32'd0);
    check("rst_ir_if", ir_if, NOP);
    check("rst_valid", 32'(valid_if), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    model_reset();
    imem_ready = 1'b0;
    stall      = 1'b0;
    br_taken   = 1'b0;
    jmp_en     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rand_mem  = 1'b0;
    mem_waits = 0;
    model_reset();
    @(negedge clk);

    // Zero-wait memory, data = address.
    do_reset();
    step();
    check("first_addr", imem_addr, 32'h0);
    step(); check("b2b0_pc", pc_if, 32'h0); check("b2b0_ir", ir_if, 32'h0);
    step(); check("b2b1_pc", pc_if, 32'h4); check("b2b1_ir", ir_if, 32'h4);
    step(); check("b2b2_pc", pc_if, 32'h8); check("b2b2_v", 32'(valid_if), 32'd1);

    // Two wait states on the fetch of 0x4.
    do_reset();
    step(); step();
    mem_waits = 2;
    for (int i = 0; i < 3; i++) begin
      check("ws_addr", imem_addr, 32'h4);
      step();
      check("ws_valid", 32'(valid_if), (i == 2) ? 32'd1 : 32'd0);
    end
    check("ws_pc", pc_if, 32'h4);
    mem_waits = 0;

    // Stall arriving with the response for 0x8.
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      check("hold_req", 32'(imem_req), 32'd0);
      check("hold_pc", pc_if, 32'h4);
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
    end
    step();
    check("unstall_pc", pc_if, 32'h8);
    check("unstall_addr", imem_addr, 32'hC);

    // Branch while the fetch of 0x10 is pending.
    step();
    mem_waits = 1;
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 26'd0, 32'd0);
    check("disc_addr", imem_addr, 32'h10);
    check("disc_valid", 32'(valid_if), 32'd0);
    step();
    mem_waits = 0;
    check("br_addr", imem_addr, 32'h100);
    check("br_valid", 32'(valid_if), 32'd0);
    step();
    check("br_pc", pc_if, 32'h100);

    // Jumps, branch priority and target wrap.
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 26'h40, 32'h4000_0000);
    check("jmp_addr", imem_addr, 32'h4000_0100);
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 26'h40, 32'h4000_0000);
    check("prio_addr", imem_addr, 32'h200);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 26'h0, 32'hFFFF_FFFC);
    check("jwrap_addr", imem_addr, 32'h0);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'd0, 32'd0);
    step();
    check("pcwrap_pc", pc_if, 32'hFFFF_FFFC);
    check("pcwrap_addr", imem_addr, 32'h0);

    // Reset in the middle of a pending request.
    mem_waits = 3;
    step();
    do_reset();

    // Random traffic with random wait states.
    rand_mem  = 1'b1;
    mem_waits = 1;
    for (int i = 0; i < 600; i++) begin
      logic        s, br, j;
      logic [31:0] bt, jpc;
      logic [25:0] im;
      if (i == 300) do_reset();
      s   = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      j   = ($urandom_range(0, 11) == 0);
      bt  = $urandom & 32'hFFFF_FFFC;
      jpc = $urandom & 32'hFFFF_FFFC;
      im  = 26'($urandom);
      cycle(s, br, bt, j, im, jpc);
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
